// File: rtl/sysid_pkg.sv
// rtl/sysid_pkg.sv - register map constants and byte-lane helper for the sysid block
package sysid_pkg;

  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_TS      = 3'd1;
  localparam logic [2:0] ADDR_FEAT    = 3'd2;
  localparam logic [2:0] ADDR_HZ      = 3'd3;
  localparam logic [2:0] ADDR_UP_LO   = 3'd4;
  localparam logic [2:0] ADDR_UP_HI   = 3'd5;
  localparam logic [2:0] ADDR_SCRATCH = 3'd6;
  localparam logic [2:0] ADDR_CTRL    = 3'd7;

  localparam int CTRL_CLR    = 0;
  localparam int CTRL_FREEZE = 1;

  // Merge new_v into old_v one byte lane at a time.
  function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// rtl/sysid_uptime_counter.sv - 64-bit free-running uptime counter with clear and freeze
module sysid_uptime_counter (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        freeze,
  output logic [63:0] count
);

  logic [63:0] count_q;
  logic [63:0] count_d;

  // Clear overrides both hold and increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (!freeze) begin
      count_d = count_q + 64'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sysid_info_regs.sv
// rtl/sysid_info_regs.sv - system-ID register file with uptime counter, scratch and control
module sysid_info_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID    = 32'hAAAAAAAA,
  parameter logic [31:0] TIMESTAMP    = 32'd1400398260,
  parameter logic [31:0] FEATURES     = 32'h0000_0000,
  parameter logic [31:0] CLOCK_HZ     = 32'd50_000_000,
  parameter logic [31:0] SCRATCH_INIT = 32'h0000_0000,
  parameter int          ADDR_W       = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  logic [31:0] addr_ext;
  logic [2:0]  word_sel;
  logic        in_range;
  logic        wr_en;
  logic        clr;
  logic [63:0] count;

  logic [31:0] scratch_q, scratch_d;
  logic        freeze_q, freeze_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] readdata_q, readdata_d;
  logic        valid_q, valid_d;
  logic [31:0] rd_word;
  logic [31:0] ctrl_rd;

  assign addr_ext = 32'(address);
  assign word_sel = address[2:0];
  assign in_range = (addr_ext < 32'd8);

  // A write colliding with a read is dropped; the read is served.
  assign wr_en = write && !read && in_range;
  assign clr   = wr_en && (word_sel == ADDR_CTRL) && byteenable[0] && writedata[CTRL_CLR];

  sysid_uptime_counter u_cnt (
    .clock  (clock),
    .reset  (reset),
    .clr    (clr),
    .freeze (freeze_q),
    .count  (count)
  );

  always_comb begin
    ctrl_rd              = '0;
    ctrl_rd[CTRL_FREEZE] = freeze_q;
  end

  always_comb begin
    rd_word = '0;
    case (word_sel)
      ADDR_ID:      rd_word = SYSTEM_ID;
      ADDR_TS:      rd_word = TIMESTAMP;
      ADDR_FEAT:    rd_word = FEATURES;
      ADDR_HZ:      rd_word = CLOCK_HZ;
      ADDR_UP_LO:   rd_word = count[31:0];
      ADDR_UP_HI:   rd_word = hi_q;
      ADDR_SCRATCH: rd_word = scratch_q;
      ADDR_CTRL:    rd_word = ctrl_rd;
      default:      rd_word = '0;
    endcase
    if (!in_range) rd_word = '0;
  end

  always_comb begin
    scratch_d  = scratch_q;
    freeze_d   = freeze_q;
    hi_d       = hi_q;
    readdata_d = readdata_q;
    valid_d    = read;
    if (wr_en && word_sel == ADDR_SCRATCH) begin
      scratch_d = apply_be(scratch_q, writedata, byteenable);
    end
    if (wr_en && word_sel == ADDR_CTRL && byteenable[0]) begin
      freeze_d = writedata[CTRL_FREEZE];
    end
    if (read) begin
      readdata_d = rd_word;
      // Snapshot the high half in the same cycle the low half is sampled.
      if (in_range && word_sel == ADDR_UP_LO) hi_d = count[63:32];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch_q  <= SCRATCH_INIT;
      freeze_q   <= 1'b0;
      hi_q       <= '0;
      readdata_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      freeze_q   <= freeze_d;
      hi_q       <= hi_d;
      readdata_q <= readdata_d;
      valid_q    <= valid_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = valid_q;

endmodule

// File: tb/tb_sysid_info_regs.sv
// tb/tb_sysid_info_regs.sv - scoreboard bench for sysid_info_regs with a behavioural model
module tb_sysid_info_regs;

  localparam logic [31:0] SCR_INIT = 32'hC0DE_0001;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  sysid_info_regs #(
    .SCRATCH_INIT (SCR_INIT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .readdata      (readdata),
    .readdatavalid (readdatavalid)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          due;
    logic [31:0] data;
    int          addr;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference state: what software would see if it could peek at the block.
  logic [63:0] m_cnt;
  logic [31:0] m_hi;
  logic [31:0] m_scr;
  logic        m_frz;
  logic [63:0] inj_val;

  always @(posedge clock) cyc <= cyc + 1;

  exp_t mon_e;
  always @(negedge clock) begin
    if (readdatavalid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_valid readdata=%h expected no response at cycle %0d", readdata, cyc);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.due != cyc || readdata !== mon_e.data) begin
          errors++;
          $display("FAIL read_addr%0d got %h at cycle %0d, expected %h at cycle %0d",
                   mon_e.addr, readdata, cyc, mon_e.data, mon_e.due);
        end
      end
    end else if (q.size() > 0 && q[0].due <= cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_valid addr%0d got no readdatavalid at cycle %0d, expected %h",
               q[0].addr, cyc, q[0].data);
      void'(q.pop_front());
    end
  end

  function automatic logic [31:0] model_read(input int a);
    case (a)
      0:       return 32'hAAAAAAAA;
      1:       return 32'd1400398260;
      2:       return 32'h0;
      3:       return 32'd50_000_000;
      4:       return m_cnt[31:0];
      5:       return m_hi;
      6:       return m_scr;
      default: return {30'b0, m_frz, 1'b0};
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = '0;
    m_hi  = '0;
    m_scr = SCR_INIT;
    m_frz = 1'b0;
  endtask

  // Called at posedge+1; drives one bus cycle and returns at the following posedge+1.
  task automatic cyc_op(input bit rd, input bit wr, input int a,
                        input logic [31:0] wd, input logic [3:0] be,
                        input bit inj = 1'b0, input logic [63:0] injv = 64'h0);
    exp_t e;
    bit   clr;
    bit   nfrz;
    read       = rd;
    write      = wr;
    address    = a[2:0];
    writedata  = wd;
    byteenable = be;
    if (inj) begin
      inj_val = injv;
      force dut.u_cnt.count_q = inj_val;
      #1;
      release dut.u_cnt.count_q;
      m_cnt = injv;
    end
    if (rd) begin
      e.due  = cyc + 1;
      e.data = model_read(a);
      e.addr = a;
      q.push_back(e);
      if (a == 4) m_hi = m_cnt[63:32];
    end
    clr  = 1'b0;
    nfrz = m_frz;
    if (wr && !rd) begin
      if (a == 6) begin
        for (int i = 0; i < 4; i++) if (be[i]) m_scr[8*i +: 8] = wd[8*i +: 8];
      end
      if (a == 7 && be[0]) begin
        clr  = wd[0];
        nfrz = wd[1];
      end
    end
    if (clr)         m_cnt = 64'h0;
    else if (!m_frz) m_cnt = m_cnt + 64'd1;
    m_frz = nfrz;
    @(posedge clock);
    #1;
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if (readdata !== 32'h0 || readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL %s readdata=%h valid=%b, expected readdata=00000000 valid=0",
               tag, readdata, readdatavalid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    logic [31:0] wd;
    logic [3:0]  be;
    bit rd, wr;

    repeat (3) @(posedge clock);
    #1;
    check_idle_outputs("reset_state");
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 8; i++) cyc_op(1'b1, 1'b0, i, 32'h0, 4'h0);

    cyc_op(1'b0, 1'b1, 6, 32'h12345678, 4'b1111);
    cyc_op(1'b0, 1'b1, 6, 32'hFFFFFFFF, 4'b0101);
    cyc_op(1'b1, 1'b0, 6, 32'h0, 4'h0);

    cyc_op(1'b0, 1'b1, 7, 32'h2, 4'hF);
    cyc_op(1'b1, 1'b0, 4, 32'h0, 4'h0);
    repeat (100) cyc_op(1'b0, 1'b0, 0, 32'h0, 4'h0);
    cyc_op(1'b1, 1'b0, 4, 32'h0, 4'h0);
    cyc_op(1'b0, 1'b1, 7, 32'h3, 4'hF);
    cyc_op(1'b1, 1'b0, 4, 32'h0, 4'h0);
    cyc_op(1'b1, 1'b0, 7, 32'h0, 4'h0);

    cyc_op(1'b0, 1'b1, 7, 32'h1, 4'hF);
    cyc_op(1'b1, 1'b0, 4, 32'h0, 4'h0);
    cyc_op(1'b1, 1'b0, 4, 32'h0, 4'h0);

    cyc_op(1'b1, 1'b0, 4, 32'h0, 4'h0, 1'b1, 64'h0000_0001_FFFF_FFFE);
    repeat (5) cyc_op(1'b0, 1'b0, 0, 32'h0, 4'h0);
    cyc_op(1'b1, 1'b0, 5, 32'h0, 4'h0);

    cyc_op(1'b1, 1'b0, 4, 32'h0, 4'h0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    cyc_op(1'b1, 1'b0, 5, 32'h0, 4'h0);
    cyc_op(1'b1, 1'b0, 4, 32'h0, 4'h0);
    cyc_op(1'b1, 1'b0, 5, 32'h0, 4'h0);

    cyc_op(1'b1, 1'b1, 6, 32'hDEADBEEF, 4'hF);
    cyc_op(1'b1, 1'b0, 6, 32'h0, 4'h0);

    for (int n = 0; n < 400; n++) begin
      a  = int'($urandom_range(0, 7));
      rd = ($urandom_range(0, 2) == 0);
      wr = ($urandom_range(0, 2) == 0);
      wd = $urandom;
      be = 4'($urandom);
      if (a == 7) begin
        wd = 32'($urandom_range(0, 3));
        be = 4'hF;
      end
      cyc_op(rd, wr, a, wd, be);
    end

    cyc_op(1'b0, 1'b1, 6, 32'h5555AAAA, 4'hF);
    cyc_op(1'b1, 1'b0, 6, 32'h0, 4'h0);
    reset = 1'b1;
    q.delete();
    #1;
    check_idle_outputs("reset_mid_read");
    @(posedge clock);
    #1;
    check_idle_outputs("reset_held");
    reset = 1'b0;
    model_reset();
    cyc_op(1'b1, 1'b0, 6, 32'h0, 4'h0);
    cyc_op(1'b1, 1'b0, 4, 32'h0, 4'h0);
    cyc_op(1'b1, 1'b0, 4, 32'h0, 4'h0);
    cyc_op(1'b1, 1'b0, 5, 32'h0, 4'h0);

    repeat (3) cyc_op(1'b0, 1'b0, 0, 32'h0, 4'h0);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sysid_info_regs.md
# sysid_info_regs

Parametrised system-identification register block: the next generation of the Qsys sysid slave. It extends the fixed two-word ID/timestamp read-out into an 8-word Avalon-MM register file with build constants, a 64-bit uptime counter with coherent split reads, a scratch register and a control register. It sits on the Nios processor's data master beside the other proc peripherals. Software uses it to identify the bitstream, measure elapsed time and test bus access.

## Interface
Parameters:
- SYSTEM_ID, 32'hAAAAAAAA: value of word 0.
- TIMESTAMP, 32'd1400398260: build timestamp, word 1.
- FEATURES, 32'h0000_0000: feature bitmask, word 2.
- CLOCK_HZ, 32'd50_000_000: clock frequency reported in word 3.
- SCRATCH_INIT, 32'h0000_0000: reset value of the scratch register.
- ADDR_W, 3: word-address width; must be ≥3.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  ADDR_W  word address.
- read  in  1  read strobe.
- write  in  1  write strobe.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for writes.
- readdata  out  32  registered read data.
- readdatavalid  out  1  one-cycle pulse qualifying readdata.

## Operation
Register map (word address, access, content):
- 0, RO: SYSTEM_ID.
- 1, RO: TIMESTAMP.
- 2, RO: FEATURES.
- 3, RO: CLOCK_HZ.
- 4, RO: UPTIME_LO, the low 32 bits of the counter. A read of this word also copies the counter's high 32 bits, from the same cycle, into the HI shadow.
- 5, RO: HI shadow. It changes only when UPTIME_LO is read.
- 6, RW: SCRATCH. Each byte is written only when its byteenable bit is 1.
- 7, RW: CONTROL.
  - bit0 CLR: writing 1 zeroes the counter. Self-clearing; always reads 0.
  - bit1 FREEZE: while 1, the counter holds its value.
  - bits 31:2 read 0.
- Addresses ≥8 (when ADDR_W>3) read 0; writes to them are ignored.
- Writes to the RO words (0–5) are ignored.

Uptime counter:
- 64-bit, +1 every clock while FREEZE=0.
- Wraps from 2^64−1 to 0 with no flag.
- When CLR and increment fall in the same cycle, CLR wins: the next value is 0.
- CLR applies even while FREEZE=1.

Simultaneous read and write in one cycle is illegal on Avalon. If it occurs, the read is served and the write is dropped.

## Timing
- Read latency is fixed at 1 cycle:
  - read high in cycle N gives readdatavalid=1 and valid readdata in cycle N+1.
  - readdata holds its value otherwise; readdatavalid is low otherwise.
- There is no waitrequest. A read or write is accepted every cycle, so back-to-back reads produce back-to-back valid pulses.
- UPTIME_LO read in cycle N:
  - readdata in N+1 = count[31:0] as it stood in cycle N.
  - The HI shadow takes count[63:32] from cycle N, at the same edge.
- Writes take effect at the edge ending the write cycle:
  - A scratch read in the next cycle returns the new value.
  - CLR written in cycle N makes count 0 in cycle N+1; it increments again from N+2.
- Reset (asynchronous, any time, including mid-read):
  - readdata=0, readdatavalid=0.
  - counter=0, HI shadow=0.
  - SCRATCH=SCRATCH_INIT, FREEZE=0.
  - A read in flight is lost; no valid pulse is issued.
  - Counting resumes in the first cycle after reset deasserts.

## Structure
- Package sysid_pkg holds:
  - address constants: ADDR_ID, ADDR_TS, ADDR_FEAT, ADDR_HZ, ADDR_UP_LO, ADDR_UP_HI, ADDR_SCRATCH, ADDR_CTRL.
  - CONTROL bit positions: CTRL_CLR=0, CTRL_FREEZE=1.
- One sub-module, sysid_uptime_counter:
  - inputs: clock, reset, clr, freeze.
  - output: count[63:0].
- The top level holds the address decode, scratch and control registers, the HI shadow and the read pipeline register.

## Test plan
- Read-out after reset: read addresses 0–3 with default parameters → 32'hAAAAAAAA, 32'd1400398260, 0, 32'd50_000_000, each with readdatavalid exactly one cycle after read.
- Scratch byte lanes: write 32'h12345678 with byteenable 4'b1111, then writedata 32'hFFFFFFFF with byteenable 4'b0101 → read returns 32'h12FF56FF.
- Coherent split read: force count to 64'h0000_0001_FFFF_FFFE and read LO then HI across the wrap → LO=32'hFFFFFFFE, HI=32'h1, not 32'h2.
- Freeze and clear: set FREEZE, wait 100 cycles → two LO reads are equal. Write CLR=1 while frozen → LO reads 0, and CONTROL bit0 reads 0.
- CLR versus increment: write CTRL=1 (FREEZE=0) → count is 0 in the next cycle and 1 in the cycle after. 64-bit wrap: 64'hFFFF_FFFF_FFFF_FFFF → 0.
- Reset mid-read: assert reset in the cycle after read → readdatavalid stays 0, SCRATCH returns to SCRATCH_INIT, counter restarts from 0.
